// File: rtl/milano_pkg.sv
// -----------------------------------------------------------------------------
// milano_pkg
//   Shared types for the Milano pipeline controller.
//   ctrl_state_e : controller FSM states, encoded to match the state_o port.
//   fwd_sel_e    : operand source select driven on fwd_rsN_sel_o.
// -----------------------------------------------------------------------------
package milano_pkg;

   typedef enum logic [1:0] {
      CTRL_RUN     = 2'd0,
      CTRL_MC_WAIT = 2'd1,
      CTRL_FLUSH   = 2'd2
   } ctrl_state_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_EX = 2'd1,
      FWD_WB = 2'd2
   } fwd_sel_e;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CNT_W      = 16;

endpackage : milano_pkg

// File: rtl/milano_hazard_unit.sv
// -----------------------------------------------------------------------------
// milano_hazard_unit
//   Dependency check of one ID-stage source operand against the EX and WB
//   destination registers. Purely combinational.
//   Optional feature macro: MILANO_FWD_EN (operand forwarding).
//
//   Ports
//     id_valid_i, rs_use_i, rs_addr_i        : ID operand being checked
//     ex_valid_i, ex_rd_addr_i, ex_rd_wr_en_i,
//     ex_is_load_i                           : EX-stage producer
//     wb_valid_i, wb_rd_addr_i, wb_rd_wr_en_i: WB-stage producer
//     hazard_o                               : operand must wait (stall)
//     fwd_sel_o                              : operand source (RF / EX / WB)
// -----------------------------------------------------------------------------
module milano_hazard_unit
   import milano_pkg::*;
(
   input  logic                  id_valid_i,
   input  logic                  rs_use_i,
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic                  ex_valid_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_rd_wr_en_i,
   input  logic                  ex_is_load_i,
   input  logic                  wb_valid_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic                  wb_rd_wr_en_i,
   output logic                  hazard_o,
   output fwd_sel_e              fwd_sel_o
);

   logic rs_live;
   logic ex_match;
   logic wb_match;
   logic ex_load_match;
   logic ex_alu_match;

   // x0 is hard-wired zero, so a read of it never depends on a producer.
   assign rs_live  = id_valid_i & rs_use_i & (rs_addr_i != '0);
   assign ex_match = rs_live & ex_valid_i & ex_rd_wr_en_i & (ex_rd_addr_i == rs_addr_i);
   assign wb_match = rs_live & wb_valid_i & wb_rd_wr_en_i & (wb_rd_addr_i == rs_addr_i);

   assign ex_load_match = ex_match & ex_is_load_i;
   assign ex_alu_match  = ex_match & ~ex_is_load_i;

`ifdef MILANO_FWD_EN
   // Load data only exists after memory access, so it cannot be forwarded
   // from EX; everything else is bypassed, youngest producer (EX) first.
   assign hazard_o  = ex_load_match;
   assign fwd_sel_o = ex_match ? FWD_EX : (wb_match ? FWD_WB : FWD_RF);
`else
   // No bypass network: any in-flight producer forces the operand to wait.
   assign hazard_o  = ex_load_match | ex_alu_match | wb_match;
   assign fwd_sel_o = FWD_RF;
`endif

endmodule : milano_hazard_unit

// File: rtl/milano_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// milano_pipe_ctrl
//   Pipeline controller: branch flush, multicycle-op wait and data-hazard
//   stall generation, operand forwarding selects and a stall-cycle counter.
//   Optional feature macro: MILANO_FWD_EN (enables forwarding; see
//   milano_hazard_unit).
//
//   Ports
//     clk_i, rst_i                     : clock, synchronous active-high reset
//     id_*                             : ID-stage operand info
//     ex_*, branch_taken_i             : EX-stage producer / control events
//     wb_*                             : WB-stage producer
//     if_stall_o, id_stall_o,
//     ex_stall_o                       : hold the respective stage
//     ex_bubble_o                      : insert NOP into ID/EX
//     flush_o                          : kill IF/ID
//     fwd_rs1_sel_o, fwd_rs2_sel_o     : 0 regfile, 1 EX, 2 WB
//     state_o                          : current FSM state
//     stall_cnt_o                      : saturating count of IF stall cycles
// -----------------------------------------------------------------------------
module milano_pipe_ctrl
   import milano_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_use_i,
   input  logic                  id_rs2_use_i,
   input  logic                  ex_valid_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_rd_wr_en_i,
   input  logic                  ex_is_load_i,
   input  logic                  ex_mc_start_i,
   input  logic                  ex_mc_done_i,
   input  logic                  branch_taken_i,
   input  logic                  wb_valid_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic                  wb_rd_wr_en_i,
   output logic                  if_stall_o,
   output logic                  id_stall_o,
   output logic                  ex_stall_o,
   output logic                  ex_bubble_o,
   output logic                  flush_o,
   output logic [1:0]            fwd_rs1_sel_o,
   output logic [1:0]            fwd_rs2_sel_o,
   output logic [1:0]            state_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic     rs1_hazard, rs2_hazard;
   fwd_sel_e rs1_fwd, rs2_fwd;
   logic     data_hazard;

   milano_hazard_unit u_hazard_rs1 (
      .id_valid_i    (id_valid_i),
      .rs_use_i      (id_rs1_use_i),
      .rs_addr_i     (id_rs1_addr_i),
      .ex_valid_i    (ex_valid_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_rd_wr_en_i (ex_rd_wr_en_i),
      .ex_is_load_i  (ex_is_load_i),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_rd_wr_en_i (wb_rd_wr_en_i),
      .hazard_o      (rs1_hazard),
      .fwd_sel_o     (rs1_fwd)
   );

   milano_hazard_unit u_hazard_rs2 (
      .id_valid_i    (id_valid_i),
      .rs_use_i      (id_rs2_use_i),
      .rs_addr_i     (id_rs2_addr_i),
      .ex_valid_i    (ex_valid_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_rd_wr_en_i (ex_rd_wr_en_i),
      .ex_is_load_i  (ex_is_load_i),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_rd_wr_en_i (wb_rd_wr_en_i),
      .hazard_o      (rs2_hazard),
      .fwd_sel_o     (rs2_fwd)
   );

   assign data_hazard = rs1_hazard | rs2_hazard;

   // Next-state and control outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      if_stall_o  = 1'b0;
      id_stall_o  = 1'b0;
      ex_stall_o  = 1'b0;
      ex_bubble_o = 1'b0;
      flush_o     = 1'b0;

      unique case (state_q)
         CTRL_RUN: begin
            // Priority: taken branch, then multicycle issue, then data hazard.
            if (branch_taken_i) begin
               flush_o     = 1'b1;
               ex_bubble_o = 1'b1;
               state_d     = CTRL_FLUSH;
            end else if (ex_mc_start_i) begin
               // A result ready in the issue cycle needs no wait state.
               if (!ex_mc_done_i) begin
                  state_d = CTRL_MC_WAIT;
               end
            end else if (data_hazard) begin
               if_stall_o  = 1'b1;
               id_stall_o  = 1'b1;
               ex_bubble_o = 1'b1;
            end
         end

         CTRL_MC_WAIT: begin
            if (ex_mc_done_i) begin
               state_d = CTRL_RUN;
            end else begin
               if_stall_o = 1'b1;
               id_stall_o = 1'b1;
               ex_stall_o = 1'b1;
            end
         end

         CTRL_FLUSH: begin
            // Second flush cycle kills the fetch already in flight.
            flush_o     = 1'b1;
            ex_bubble_o = 1'b1;
            state_d     = CTRL_RUN;
         end

         default: begin
            // Unreachable encoding: recover to RUN.
            state_d = CTRL_RUN;
         end
      endcase

      // Reset silences every control output in the same cycle.
      if (rst_i) begin
         if_stall_o  = 1'b0;
         id_stall_o  = 1'b0;
         ex_stall_o  = 1'b0;
         ex_bubble_o = 1'b0;
         flush_o     = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (if_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst_i) begin
         state_q     <= CTRL_RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fwd_rs1_sel_o = rst_i ? 2'd0 : rs1_fwd;
   assign fwd_rs2_sel_o = rst_i ? 2'd0 : rs2_fwd;
   assign state_o       = state_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule : milano_pipe_ctrl
